// File: rtl/noc_params_pkg.sv
// Shared NoC router types: flit type, output port, input-port FSM state.
// Imported by the route computation and the input port controller.
package noc_params_pkg;

  localparam int PORT_W = 3;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'b00,
    FLIT_BODY     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic [PORT_W-1:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_SOUTH = 3'd2,
    PORT_WEST  = 3'd3,
    PORT_EAST  = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VA     = 2'd1,
    ST_ACTIVE = 2'd2
  } ipc_state_e;

endpackage

// File: rtl/xy_route_compute.sv
// Dimension-ordered (X then Y) output port selection for a head flit.
// Purely combinational, no latency, no flow control.
module xy_route_compute
  import noc_params_pkg::*;
#(
  parameter int COORD_SIZE = 2,
  parameter int LOCAL_X    = 0,
  parameter int LOCAL_Y    = 0
) (
  input  logic [COORD_SIZE-1:0] dest_x,
  input  logic [COORD_SIZE-1:0] dest_y,
  output logic [PORT_W-1:0]     route
);

  localparam logic [COORD_SIZE-1:0] LX = COORD_SIZE'(LOCAL_X);
  localparam logic [COORD_SIZE-1:0] LY = COORD_SIZE'(LOCAL_Y);

  always_comb begin
    route = PORT_LOCAL;
    if (dest_x > LX)      route = PORT_EAST;
    else if (dest_x < LX) route = PORT_WEST;
    else if (dest_y > LY) route = PORT_NORTH;
    else if (dest_y < LY) route = PORT_SOUTH;
  end

endmodule

// File: rtl/input_port_ctrl.sv
// Router input port: XY route, VA/SA requests, pop on SA grant, flit out 1 cycle after grant.
// Stalls on empty buffer or zero downstream credits; NOC_PROTOCOL_CHECK_EN enables sticky error_o.
module input_port_ctrl
  import noc_params_pkg::*;
#(
  parameter int FLIT_SIZE        = 8,
  parameter int COORD_SIZE       = 2,
  parameter int LOCAL_X          = 0,
  parameter int LOCAL_Y          = 0,
  parameter int DOWNSTREAM_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] buf_data_i,
  input  logic                 buf_is_empty_i,
  output logic                 buf_read_o,
  output logic                 va_request_o,
  input  logic                 va_grant_i,
  output logic                 sa_request_o,
  input  logic                 sa_grant_i,
  output logic [PORT_W-1:0]    out_port_o,
  output logic [FLIT_SIZE-1:0] flit_o,
  output logic                 flit_valid_o,
  input  logic                 credit_i,
  output logic                 credit_o,
  output logic                 error_o
);

  localparam int CW = $clog2(DOWNSTREAM_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(DOWNSTREAM_DEPTH);

  ipc_state_e      state;
  logic [CW-1:0]   credits;
  flit_type_e      head_type;
  logic            head_is_first;
  logic            head_is_last;
  logic            idle_discard;
  logic            fwd_pop;
  logic [PORT_W-1:0] route;

  assign head_type     = flit_type_e'(buf_data_i[FLIT_SIZE-1 -: 2]);
  assign head_is_first = (head_type == FLIT_HEAD) || (head_type == FLIT_HEADTAIL);
  assign head_is_last  = (head_type == FLIT_TAIL) || (head_type == FLIT_HEADTAIL);

  xy_route_compute #(
    .COORD_SIZE (COORD_SIZE),
    .LOCAL_X    (LOCAL_X),
    .LOCAL_Y    (LOCAL_Y)
  ) u_route (
    .dest_x (buf_data_i[2*COORD_SIZE-1:COORD_SIZE]),
    .dest_y (buf_data_i[COORD_SIZE-1:0]),
    .route  (route)
  );

  // Stray body/tail flits outside a packet are drained so the port cannot wedge.
  assign idle_discard = (state == ST_IDLE) && !buf_is_empty_i && !head_is_first;
  assign sa_request_o = (state == ST_ACTIVE) && !buf_is_empty_i && (credits != '0);
  assign fwd_pop      = sa_request_o && sa_grant_i && !rst;
  assign buf_read_o   = fwd_pop || (idle_discard && !rst);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      va_request_o <= 1'b0;
      out_port_o   <= PORT_LOCAL;
      flit_o       <= '0;
      flit_valid_o <= 1'b0;
      credit_o     <= 1'b0;
      credits      <= CRED_MAX;
    end else begin
      flit_valid_o <= fwd_pop;
      credit_o     <= buf_read_o;
      if (fwd_pop) flit_o <= buf_data_i;

      // Simultaneous pop and return cancel; returns beyond the depth saturate.
      if (fwd_pop && !credit_i)
        credits <= credits - 1'b1;
      else if (credit_i && !fwd_pop && (credits != CRED_MAX))
        credits <= credits + 1'b1;

      case (state)
        ST_IDLE: begin
          if (!buf_is_empty_i && head_is_first) begin
            out_port_o   <= route;
            va_request_o <= 1'b1;
            state        <= ST_VA;
          end
        end
        ST_VA: begin
          if (va_grant_i) begin
            va_request_o <= 1'b0;
            state        <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (fwd_pop && head_is_last) state <= ST_IDLE;
        end
        default: begin
          va_request_o <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NOC_PROTOCOL_CHECK_EN
  logic err_q;
  logic cred_overflow;

  assign cred_overflow = credit_i && !fwd_pop && (credits == CRED_MAX);

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (idle_discard || (fwd_pop && (head_type == FLIT_HEAD)) || cred_overflow)
      err_q <= 1'b1;
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
// Randomized bench for input_port_ctrl against a packet-level reference model.
module tb_input_port_ctrl;

  localparam int FS = 8;
  localparam int CS = 2;
  localparam int LX = 1;
  localparam int LY = 1;
  localparam int D  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [FS-1:0] buf_data_i;
  logic          buf_is_empty_i;
  logic          buf_read_o;
  logic          va_request_o;
  logic          va_grant_i;
  logic          sa_request_o;
  logic          sa_grant_i;
  logic [2:0]    out_port_o;
  logic [FS-1:0] flit_o;
  logic          flit_valid_o;
  logic          credit_i;
  logic          credit_o;
  logic          error_o;

  always #5 clk = ~clk;

  input_port_ctrl #(
    .FLIT_SIZE        (FS),
    .COORD_SIZE       (CS),
    .LOCAL_X          (LX),
    .LOCAL_Y          (LY),
    .DOWNSTREAM_DEPTH (D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .buf_data_i     (buf_data_i),
    .buf_is_empty_i (buf_is_empty_i),
    .buf_read_o     (buf_read_o),
    .va_request_o   (va_request_o),
    .va_grant_i     (va_grant_i),
    .sa_request_o   (sa_request_o),
    .sa_grant_i     (sa_grant_i),
    .out_port_o     (out_port_o),
    .flit_o         (flit_o),
    .flit_valid_o   (flit_valid_o),
    .credit_i       (credit_i),
    .credit_o       (credit_o),
    .error_o        (error_o)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc_now  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc_now);
    end
  endtask

  // Upstream buffer contents and the pending packet stream feeding it
  logic [7:0] q[$];
  logic [7:0] src[$];

  function automatic logic [7:0] mkf(input int t, input int x, input int y);
    logic [7:0] f;
    f = {2'(t), 2'($urandom_range(0, 3)), 2'(x), 2'(y)};
    return f;
  endfunction

  function automatic int xy_port(input int dx, input int dy);
    if (dx > LX) return 4;
    if (dx < LX) return 3;
    if (dy > LY) return 1;
    if (dy < LY) return 2;
    return 0;
  endfunction

  task automatic gen_packet();
    int k;
    int n;
    k = $urandom_range(0, 9);
    if (k == 0) src.push_back(mkf(1, $urandom_range(0, 3), $urandom_range(0, 3)));
    else if (k == 1) src.push_back(mkf(2, $urandom_range(0, 3), $urandom_range(0, 3)));
    else if (k == 2) src.push_back(mkf(3, $urandom_range(0, 3), $urandom_range(0, 3)));
    else if (k == 3) begin
      src.push_back(mkf(0, $urandom_range(0, 3), $urandom_range(0, 3)));
      src.push_back(mkf(1, $urandom_range(0, 3), $urandom_range(0, 3)));
    end else begin
      n = $urandom_range(0, 3);
      src.push_back(mkf(0, $urandom_range(0, 3), $urandom_range(0, 3)));
      for (int i = 0; i < n; i++) src.push_back(mkf(1, $urandom_range(0, 3), $urandom_range(0, 3)));
      src.push_back(mkf(2, $urandom_range(0, 3), $urandom_range(0, 3)));
    end
  endtask

  // Reference model: packet progress flags plus expected registered outputs
  bit         have_head, have_vc;
  int         m_port, m_credits;
  bit         m_fvld, m_cred, m_err;
  logic [7:0] m_flit;
  bit         pend_pop;

  task automatic model_reset();
    have_head = 0; have_vc = 0;
    m_port = 0; m_credits = D;
    m_fvld = 0; m_cred = 0; m_err = 0;
    m_flit = 8'h00;
  endtask

  initial begin
    bit   empty, fwd, discard, exp_va, exp_sa, exp_rd, ovf;
    int   typ, c, exp_err;
    logic [7:0] hd;

    rst = 1'b1; va_grant_i = 1'b0; sa_grant_i = 1'b0; credit_i = 1'b0;
    buf_data_i = '0; buf_is_empty_i = 1'b1;
    model_reset();
    pend_pop = 0;

    // Directed opening: 3-flit packet to EAST, HEADTAIL to SOUTH, stray BODY
    src.push_back(mkf(0, 3, 1));
    src.push_back(mkf(1, 0, 0));
    src.push_back(mkf(2, 0, 0));
    src.push_back(mkf(3, 1, 0));
    src.push_back(mkf(1, 2, 2));

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      cyc_now = cyc;
      if (pend_pop) void'(q.pop_front());
      pend_pop = 0;

      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      if (src.size() == 0) gen_packet();
      if (q.size() < 4 && $urandom_range(0, 3) != 0) q.push_back(src.pop_front());
      buf_is_empty_i = (q.size() == 0);
      buf_data_i     = buf_is_empty_i ? 8'h00 : q[0];
      va_grant_i     = ($urandom_range(0, 2) == 0);
      sa_grant_i     = (cyc < 60) ? 1'b1 : ($urandom_range(0, 9) < 7);
      credit_i       = ((D - m_credits) > 0 && $urandom_range(0, 3) == 0) ||
                       ($urandom_range(0, 99) == 0);
      #1;

      empty   = buf_is_empty_i;
      hd      = buf_data_i;
      typ     = int'(hd[7:6]);
      exp_va  = have_head && !have_vc;
      exp_sa  = have_vc && !empty && (m_credits > 0);
      fwd     = exp_sa && sa_grant_i && !rst;
      discard = !have_head && !empty && (typ == 1 || typ == 2) && !rst;
      exp_rd  = fwd || discard;
`ifdef NOC_PROTOCOL_CHECK_EN
      exp_err = int'(m_err);
`else
      exp_err = 0;
`endif

      check_eq("buf_read",  int'(buf_read_o),   int'(exp_rd));
      check_eq("va_req",    int'(va_request_o), int'(exp_va));
      check_eq("sa_req",    int'(sa_request_o), int'(exp_sa));
      check_eq("flit_vld",  int'(flit_valid_o), int'(m_fvld));
      check_eq("flit",      int'(flit_o),       int'(m_flit));
      check_eq("credit_o",  int'(credit_o),     int'(m_cred));
      check_eq("out_port",  int'(out_port_o),   m_port);
      check_eq("error",     int'(error_o),      exp_err);
      check_eq("credits",   int'(dut.credits),  m_credits);

      if (rst) begin
        model_reset();
      end else begin
        m_fvld = fwd;
        m_cred = exp_rd;
        if (fwd) m_flit = hd;
        if (discard) m_err = 1;
        c   = m_credits - int'(fwd) + int'(credit_i);
        ovf = (c > D);
        if (ovf) begin
          c = D;
          m_err = 1;
        end
        m_credits = c;
        if (have_head && have_vc) begin
          if (fwd && typ == 0) m_err = 1;
          if (fwd && (typ == 2 || typ == 3)) begin
            have_head = 0;
            have_vc   = 0;
          end
        end else if (have_head) begin
          if (va_grant_i) have_vc = 1;
        end else if (!empty && (typ == 0 || typ == 3)) begin
          have_head = 1;
          m_port    = xy_port(int'(hd[3:2]), int'(hd[1:0]));
        end
      end
      pend_pop = exp_rd;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
